// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm-directory blocks: fade FSM state encoding and width.
package pwm_pkg;

    localparam int unsigned STATE_WIDTH = 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        StIdle = 2'd0,
        StRise = 2'd1,
        StHold = 2'd2,
        StFall = 2'd3
    } pwm_state_e;

endpackage

// File: rtl/pwm_generator.sv
// Free-running PWM counter with a shadow duty register that only updates at period wrap,
// so a duty change never produces a runt pulse.
module pwm_generator #(
    parameter int unsigned DUTY_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DUTY_WIDTH-1:0] i_duty,
    output logic                  o_pwm
);

    localparam logic [DUTY_WIDTH-1:0] DutyMax = {DUTY_WIDTH{1'b1}};

    logic [DUTY_WIDTH-1:0] cnt_q;
    logic [DUTY_WIDTH-1:0] shadow_q;
    logic                  pwm_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            cnt_q <= cnt_q + DUTY_WIDTH'(1);
            if (cnt_q == DutyMax) begin
                shadow_q <= i_duty;
            end
            pwm_q <= (cnt_q < shadow_q);
        end
    end

    assign o_pwm = pwm_q;

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Fade sequencer: ramps duty up on ticks, holds for a number of beats, ramps down, then
// signals completion; drives a glitch-free PWM generator.
module pwm_fade_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned DUTY_WIDTH = 8,
    parameter int unsigned FADE_STEP  = 4,
    parameter int unsigned HOLD_BEATS = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic                   i_tick_stb,
    input  logic                   i_beat_stb,
    output logic                   o_pwm,
    output logic [DUTY_WIDTH-1:0]  o_duty,
    output logic [STATE_WIDTH-1:0] o_state,
    output logic                   o_cycle_done
);

    // A zero-width counter is illegal, so HOLD_BEATS=0 still gets one bit.
    localparam int unsigned BeatWidth = (HOLD_BEATS > 0) ? $clog2(HOLD_BEATS + 1) : 1;
    localparam logic [BeatWidth-1:0]  HoldBeatsW = BeatWidth'(HOLD_BEATS);
    localparam logic [DUTY_WIDTH:0]   MaxExt     = {1'b0, {DUTY_WIDTH{1'b1}}};
    localparam logic [DUTY_WIDTH:0]   StepExt    = (DUTY_WIDTH + 1)'(FADE_STEP);

    pwm_state_e            state_q, state_d;
    logic [DUTY_WIDTH-1:0] duty_q, duty_d;
    logic [BeatWidth-1:0]  beat_q, beat_d;
    logic                  done_q, done_d;

    logic [DUTY_WIDTH:0]   rise_sum;
    logic [BeatWidth-1:0]  beat_inc;

    assign rise_sum = {1'b0, duty_q} + StepExt;
    assign beat_inc = beat_q + BeatWidth'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            duty_q  <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        beat_d  = beat_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                duty_d = '0;
                if (i_beat_stb && i_enable) begin
                    state_d = StRise;
                end
            end
            StRise: begin
                // Losing enable mid-ramp fades out from wherever duty currently sits.
                if (!i_enable) begin
                    state_d = StFall;
                end else if (i_tick_stb) begin
                    if (rise_sum >= MaxExt) begin
                        duty_d  = MaxExt[DUTY_WIDTH-1:0];
                        beat_d  = '0;
                        state_d = StHold;
                    end else begin
                        duty_d = rise_sum[DUTY_WIDTH-1:0];
                    end
                end
            end
            StHold: begin
                if (!i_enable || (HOLD_BEATS == 0)) begin
                    state_d = StFall;
                end else if (i_beat_stb) begin
                    beat_d = beat_inc;
                    if (beat_inc == HoldBeatsW) begin
                        state_d = StFall;
                    end
                end
            end
            StFall: begin
                if (i_tick_stb) begin
                    if ({1'b0, duty_q} <= StepExt) begin
                        duty_d  = '0;
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        duty_d = duty_q - StepExt[DUTY_WIDTH-1:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    pwm_generator #(
        .DUTY_WIDTH(DUTY_WIDTH)
    ) u_pwm_generator (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_duty (duty_q),
        .o_pwm  (o_pwm)
    );

    assign o_duty       = duty_q;
    assign o_state      = state_q;
    assign o_cycle_done = done_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Self-checking bench: per-cycle behavioural model plus directed literal expectations.
module tb_pwm_fade_sequencer;

    localparam int DW   = 8;
    localparam int STEP = 64;
    localparam int HB   = 2;
    localparam int MAXV = 255;

    logic          i_clk        = 1'b0;
    logic          i_rst_n      = 1'b1;
    logic          i_enable     = 1'b0;
    logic          i_tick_stb   = 1'b0;
    logic          i_beat_stb   = 1'b0;
    logic          o_pwm;
    logic [DW-1:0] o_duty;
    logic [1:0]    o_state;
    logic          o_cycle_done;

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;

    pwm_fade_sequencer #(
        .DUTY_WIDTH(DW),
        .FADE_STEP (STEP),
        .HOLD_BEATS(HB)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_enable    (i_enable),
        .i_tick_stb  (i_tick_stb),
        .i_beat_stb  (i_beat_stb),
        .o_pwm       (o_pwm),
        .o_duty      (o_duty),
        .o_state     (o_state),
        .o_cycle_done(o_cycle_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0..3, integer duty, beat count, PWM period position and shadow.
    int m_phase = 0, m_duty = 0, m_beats = 0, m_pos = 0, m_shadow = 0;
    int m_pwm = 0, m_done = 0;

    initial begin
        forever begin
            @(posedge i_clk);
            if (!i_rst_n) begin
                m_phase = 0; m_duty = 0; m_beats = 0; m_pos = 0; m_shadow = 0;
                m_pwm = 0; m_done = 0;
            end else begin
                int n_phase, n_duty, n_beats, n_shadow;
                m_pwm    = (m_pos < m_shadow) ? 1 : 0;
                n_shadow = (m_pos == MAXV) ? m_duty : m_shadow;
                m_pos    = (m_pos + 1) % (MAXV + 1);
                m_shadow = n_shadow;
                n_phase = m_phase; n_duty = m_duty; n_beats = m_beats;
                m_done  = 0;
                if (m_phase == 0) begin
                    if (i_beat_stb && i_enable) n_phase = 1;
                end else if (m_phase == 1) begin
                    if (!i_enable) n_phase = 3;
                    else if (i_tick_stb) begin
                        if (m_duty + STEP >= MAXV) begin
                            n_duty = MAXV; n_beats = 0; n_phase = 2;
                        end else n_duty = m_duty + STEP;
                    end
                end else if (m_phase == 2) begin
                    if (!i_enable || HB == 0) n_phase = 3;
                    else if (i_beat_stb) begin
                        n_beats = m_beats + 1;
                        if (n_beats == HB) n_phase = 3;
                    end
                end else begin
                    if (i_tick_stb) begin
                        n_duty = (m_duty > STEP) ? m_duty - STEP : 0;
                        if (n_duty == 0) begin
                            n_phase = 0; m_done = 1;
                        end
                    end
                end
                m_phase = n_phase; m_duty = n_duty; m_beats = n_beats;
            end
            #1;
            if (o_cycle_done) done_seen++;
            checks++;
            if (o_state !== 2'(m_phase) || o_duty !== DW'(m_duty) ||
                o_pwm !== 1'(m_pwm) || o_cycle_done !== 1'(m_done)) begin
                failures++;
                $display("FAIL model t=%0t: state %0d/%0d duty %0d/%0d pwm %0b/%0d done %0b/%0d",
                         $time, o_state, m_phase, o_duty, m_duty, o_pwm, m_pwm,
                         o_cycle_done, m_done);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Called at a negedge; returns at the next negedge with the strobe consumed.
    task automatic pulse(input logic beat);
        i_tick_stb = 1'b1;
        i_beat_stb = beat;
        @(negedge i_clk);
        i_tick_stb = 1'b0;
        i_beat_stb = 1'b0;
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge i_clk);
            hi += int'(o_pwm);
        end
    endtask

    int hi;
    int done_base;

    initial begin
        #1 i_rst_n = 1'b0;
        cyc(3);
        chk("reset_state", o_state, 0);
        chk("reset_duty", o_duty, 0);
        chk("reset_pwm", o_pwm, 0);
        chk("reset_done", o_cycle_done, 0);
        i_rst_n = 1'b1;
        cyc(2);

        // Full fade cycle
        i_enable = 1'b1;
        pulse(1'b1);
        chk("enter_rise_state", o_state, 1);
        chk("enter_rise_no_step", o_duty, 0);
        pulse(1'b0); chk("rise_64", o_duty, 64);
        cyc(3);
        pulse(1'b0); chk("rise_128", o_duty, 128);
        pulse(1'b0); chk("rise_192", o_duty, 192);
        pulse(1'b0); chk("rise_255", o_duty, 255);
        chk("hold_state", o_state, 2);
        pulse(1'b0); chk("hold_ignores_tick", o_state, 2);
        pulse(1'b1); chk("hold_beat1", o_state, 2);
        pulse(1'b1); chk("hold_to_fall", o_state, 3);
        chk("fall_entry_duty", o_duty, 255);
        pulse(1'b0); chk("fall_191", o_duty, 191);
        pulse(1'b0); chk("fall_127", o_duty, 127);
        pulse(1'b0); chk("fall_63", o_duty, 63);
        done_base = done_seen;
        pulse(1'b0); chk("fall_0", o_duty, 0);
        chk("cycle_idle", o_state, 0);
        chk("cycle_done_pulse", o_cycle_done, 1);
        cyc(1);
        chk("cycle_done_clear", o_cycle_done, 0);
        cyc(4);
        chk("cycle_done_once", done_seen - done_base, 1);

        // Disable mid-rise
        pulse(1'b1);
        pulse(1'b0);
        pulse(1'b0); chk("abort_rise_128", o_duty, 128);
        i_enable = 1'b0;
        cyc(1);
        chk("abort_to_fall", o_state, 3);
        chk("abort_keep_duty", o_duty, 128);
        done_base = done_seen;
        pulse(1'b0); chk("abort_fall_64", o_duty, 64);
        pulse(1'b0); chk("abort_fall_0", o_duty, 0);
        chk("abort_idle", o_state, 0);
        cyc(4);
        chk("abort_done_once", done_seen - done_base, 1);

        // Beat with enable low in IDLE
        pulse(1'b1);
        chk("disabled_beat_state", o_state, 0);
        count_high(512, hi);
        chk("disabled_pwm_low", hi, 0);
        chk("disabled_duty", o_duty, 0);

        // PWM duty 64 then 255
        i_enable = 1'b1;
        pulse(1'b1);
        cyc(37);
        pulse(1'b0); chk("pwm_duty_64", o_duty, 64);
        cyc(300);
        count_high(256, hi);
        chk("pwm_high_64", hi, 64);
        pulse(1'b0);
        pulse(1'b0);
        pulse(1'b0); chk("pwm_duty_255", o_duty, 255);
        cyc(300);
        count_high(256, hi);
        chk("pwm_high_255", hi, 255);

        // Reset asserted in HOLD
        pulse(1'b1);
        chk("pre_reset_hold", o_state, 2);
        done_base = done_seen;
        i_rst_n = 1'b0;
        #1;
        chk("rst_async_duty", o_duty, 0);
        chk("rst_async_pwm", o_pwm, 0);
        chk("rst_async_state", o_state, 0);
        chk("rst_async_done", o_cycle_done, 0);
        cyc(3);
        i_rst_n = 1'b1;
        cyc(5);
        chk("rst_no_done", done_seen - done_base, 0);
        chk("rst_wait_idle", o_state, 0);
        pulse(1'b0);
        chk("rst_tick_only_idle", o_state, 0);
        pulse(1'b1);
        chk("rst_restart_rise", o_state, 1);
        chk("rst_restart_duty", o_duty, 0);

        // Disable in HOLD forces FALL keeping duty
        pulse(1'b0); pulse(1'b0); pulse(1'b0); pulse(1'b0);
        chk("hold_again", o_state, 2);
        i_enable = 1'b0;
        cyc(1);
        chk("hold_disable_fall", o_state, 3);
        chk("hold_disable_duty", o_duty, 255);
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
